// File: rtl/miriscv_decode_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | miriscv_decode_pipe : queued, registered RV32I decode stage with flush   |
// | and an illegal-instruction counter. MIRISCV_DECODE_RVM_EN enables RV32M.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif

module miriscv_decode_pipe #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic                     clk_i,
   input  logic                     arstn_i,
   input  logic                     flush_i,

   input  logic                     instr_valid_i,
   output logic                     instr_ready_o,
   input  logic [31:0]              instr_i,
   input  logic [31:0]              pc_i,

   output logic                     dec_valid_o,
   input  logic                     dec_ready_i,
   output logic [31:0]              pc_o,
   output logic [1:0]               ex_op_a_sel_o,
   output logic [2:0]               ex_op_b_sel_o,
   output logic [`ALU_OP_WIDTH-1:0] alu_op_o,
   output logic                     mem_req_o,
   output logic                     mem_we_o,
   output logic [2:0]               mem_size_o,
   output logic                     gpr_we_a_o,
   output logic                     wb_src_sel_o,
   output logic                     branch_o,
   output logic                     jal_o,
   output logic                     jalr_o,
   output logic                     illegal_instr_o,
   output logic                     mdu_req_o,
   output logic [2:0]               mdu_op_o,
   output logic [CNT_W-1:0]         illegal_cnt_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);
   localparam int unsigned ALU_W = `ALU_OP_WIDTH;
   localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_MISC   = 5'b00011;
   localparam logic [4:0] OPC_OP_IMM = 5'b00100;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM = 5'b11100;

   localparam logic [1:0] OP_A_RS1   = 2'd0;
   localparam logic [1:0] OP_A_PC    = 2'd1;
   localparam logic [1:0] OP_A_ZERO  = 2'd2;
   localparam logic [2:0] OP_B_RS2   = 3'd0;
   localparam logic [2:0] OP_B_IMM_I = 3'd1;
   localparam logic [2:0] OP_B_IMM_U = 3'd2;
   localparam logic [2:0] OP_B_IMM_S = 3'd3;
   localparam logic [2:0] OP_B_INCR  = 3'd4;

   localparam logic WB_EX  = 1'b0;
   localparam logic WB_LSU = 1'b1;

   typedef struct packed {
      logic [1:0]       op_a;
      logic [2:0]       op_b;
      logic [ALU_W-1:0] alu;
      logic             mem_req;
      logic             mem_we;
      logic [2:0]       mem_size;
      logic             gpr_we;
      logic             wb_src;
      logic             branch;
      logic             jal;
      logic             jalr;
      logic             illegal;
      logic             mdu_req;
      logic [2:0]       mdu_op;
   } dec_t;

   // ---------------- instruction queue ----------------
   logic [63:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;

   logic push, pop, q_empty, slot_load;

   assign instr_ready_o = (occ_q != FULL_OCC);
   assign q_empty       = (occ_q == '0);
   assign push          = instr_valid_i && instr_ready_o;
   assign slot_load     = !q_empty && (!dec_valid_o || dec_ready_i);
   assign pop           = slot_load;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      occ_d  = occ_q;
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
         occ_d  = '0;
      end else begin
         if (push) wptr_d = wptr_q + PTR_W'(1);
         if (pop)  rptr_d = rptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         occ_q  <= occ_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (push && !flush_i) mem_q[wptr_q] <= {instr_i, pc_i};
   end

   // ---------------- RV32I decode of the queue head ----------------
   logic [31:0] head_instr, head_pc;
   logic [4:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic        ill;
   dec_t        dec_d;

   assign head_instr = mem_q[rptr_q][63:32];
   assign head_pc    = mem_q[rptr_q][31:0];
   assign opc        = head_instr[6:2];
   assign f3         = head_instr[14:12];
   assign f7         = head_instr[31:25];

   always_comb begin
      dec_d = '0;
      ill   = 1'b0;
      case (opc)
         OPC_LOAD: begin
            dec_d.op_b     = OP_B_IMM_I;
            dec_d.mem_req  = 1'b1;
            dec_d.mem_size = f3;
            dec_d.gpr_we   = 1'b1;
            dec_d.wb_src   = WB_LSU;
            ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
         end
         OPC_MISC: ;
         OPC_OP_IMM: begin
            dec_d.op_b   = OP_B_IMM_I;
            dec_d.gpr_we = 1'b1;
            dec_d.alu    = ALU_W'({2'b00, f3});
            if (f3 == 3'd1) begin
               ill = (f7 != 7'h00);
            end else if (f3 == 3'd5) begin
               if (f7 == 7'h20)      dec_d.alu = ALU_W'({2'b01, f3});
               else if (f7 != 7'h00) ill = 1'b1;
            end
         end
         OPC_AUIPC: begin
            dec_d.op_a   = OP_A_PC;
            dec_d.op_b   = OP_B_IMM_U;
            dec_d.gpr_we = 1'b1;
         end
         OPC_STORE: begin
            dec_d.op_b     = OP_B_IMM_S;
            dec_d.mem_req  = 1'b1;
            dec_d.mem_we   = 1'b1;
            dec_d.mem_size = f3;
            ill = (f3 > 3'd2);
         end
         OPC_OP: begin
            dec_d.gpr_we = 1'b1;
            case (f7)
               7'h00: dec_d.alu = ALU_W'({2'b00, f3});
               7'h20: begin
                  dec_d.alu = ALU_W'({2'b01, f3});
                  ill = (f3 != 3'd0) && (f3 != 3'd5);
               end
`ifdef MIRISCV_DECODE_RVM_EN
               7'h01: begin
                  dec_d.mdu_req = 1'b1;
                  dec_d.mdu_op  = f3;
               end
`endif
               default: ill = 1'b1;
            endcase
         end
         OPC_LUI: begin
            dec_d.op_a   = OP_A_ZERO;
            dec_d.op_b   = OP_B_IMM_U;
            dec_d.gpr_we = 1'b1;
         end
         OPC_BRANCH: begin
            dec_d.branch = 1'b1;
            dec_d.alu    = ALU_W'({2'b11, f3});
            ill = (f3 == 3'd2) || (f3 == 3'd3);
         end
         OPC_JALR: begin
            dec_d.op_a   = OP_A_PC;
            dec_d.op_b   = OP_B_INCR;
            dec_d.gpr_we = 1'b1;
            dec_d.jalr   = 1'b1;
            ill = (f3 != 3'd0);
         end
         OPC_JAL: begin
            dec_d.op_a   = OP_A_PC;
            dec_d.op_b   = OP_B_INCR;
            dec_d.gpr_we = 1'b1;
            dec_d.jal    = 1'b1;
         end
         OPC_SYSTEM: ill = (head_instr != 32'h0000_0073) && (head_instr != 32'h0010_0073);
         default:    ill = 1'b1;
      endcase
      if (head_instr[1:0] != 2'b11) ill = 1'b1;
      if (ill) begin
         dec_d         = '0;
         dec_d.illegal = 1'b1;
      end
   end

   // ---------------- output slot and counter ----------------
   dec_t             dec_q;
   logic             dec_valid_q;
   logic [31:0]      pc_q;
   logic [CNT_W-1:0] ill_cnt_q;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         dec_valid_q <= 1'b0;
         dec_q       <= '0;
         pc_q        <= '0;
      end else if (flush_i) begin
         dec_valid_q <= 1'b0;
      end else if (slot_load) begin
         dec_valid_q <= 1'b1;
         dec_q       <= dec_d;
         pc_q        <= head_pc;
      end else if (dec_ready_i) begin
         dec_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         ill_cnt_q <= '0;
      end else if (dec_valid_q && dec_ready_i && dec_q.illegal && !(&ill_cnt_q)) begin
         ill_cnt_q <= ill_cnt_q + CNT_W'(1);
      end
   end

   assign dec_valid_o     = dec_valid_q;
   assign pc_o            = pc_q;
   assign ex_op_a_sel_o   = dec_q.op_a;
   assign ex_op_b_sel_o   = dec_q.op_b;
   assign alu_op_o        = dec_q.alu;
   assign mem_req_o       = dec_q.mem_req;
   assign mem_we_o        = dec_q.mem_we;
   assign mem_size_o      = dec_q.mem_size;
   assign gpr_we_a_o      = dec_q.gpr_we;
   assign wb_src_sel_o    = dec_q.wb_src;
   assign branch_o        = dec_q.branch;
   assign jal_o           = dec_q.jal;
   assign jalr_o          = dec_q.jalr;
   assign illegal_instr_o = dec_q.illegal;
   assign mdu_req_o       = dec_q.mdu_req;
   assign mdu_op_o        = dec_q.mdu_op;
   assign illegal_cnt_o   = ill_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_miriscv_decode_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_miriscv_decode_pipe : directed vector bench for miriscv_decode_pipe   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_miriscv_decode_pipe;

   localparam int DEPTH = 2;
   localparam int CNT_W = 4;

   logic             clk_i = 1'b0;
   logic             arstn_i;
   logic             flush_i;
   logic             instr_valid_i;
   logic             instr_ready_o;
   logic [31:0]      instr_i;
   logic [31:0]      pc_i;
   logic             dec_valid_o;
   logic             dec_ready_i;
   logic [31:0]      pc_o;
   logic [1:0]       ex_op_a_sel_o;
   logic [2:0]       ex_op_b_sel_o;
   logic [4:0]       alu_op_o;
   logic             mem_req_o, mem_we_o;
   logic [2:0]       mem_size_o;
   logic             gpr_we_a_o, wb_src_sel_o;
   logic             branch_o, jal_o, jalr_o;
   logic             illegal_instr_o;
   logic             mdu_req_o;
   logic [2:0]       mdu_op_o;
   logic [CNT_W-1:0] illegal_cnt_o;

   miriscv_decode_pipe #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .arstn_i(arstn_i), .flush_i(flush_i),
      .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
      .instr_i(instr_i), .pc_i(pc_i),
      .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i), .pc_o(pc_o),
      .ex_op_a_sel_o(ex_op_a_sel_o), .ex_op_b_sel_o(ex_op_b_sel_o),
      .alu_op_o(alu_op_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_size_o(mem_size_o), .gpr_we_a_o(gpr_we_a_o), .wb_src_sel_o(wb_src_sel_o),
      .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o),
      .illegal_instr_o(illegal_instr_o), .mdu_req_o(mdu_req_o), .mdu_op_o(mdu_op_o),
      .illegal_cnt_o(illegal_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] pc;
      logic        ill;
      logic [1:0]  a;
      logic [2:0]  b;
      logic [4:0]  alu;
      logic        mreq, mwe;
      logic [2:0]  msz;
      logic        gwe, wb, br, jal, jalr, mdu;
      logic [2:0]  mop;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] pc, input logic ill,
                               input logic [1:0] a, input logic [2:0] b, input logic [4:0] alu,
                               input logic mreq, input logic mwe, input logic [2:0] msz,
                               input logic gwe, input logic wb, input logic br,
                               input logic jal, input logic jalr, input logic mdu,
                               input logic [2:0] mop);
      vec_t v;
      v.ins = ins; v.pc = pc; v.ill = ill; v.a = a; v.b = b; v.alu = alu;
      v.mreq = mreq; v.mwe = mwe; v.msz = msz; v.gwe = gwe; v.wb = wb;
      v.br = br; v.jal = jal; v.jalr = jalr; v.mdu = mdu; v.mop = mop;
      return v;
   endfunction

   function automatic vec_t mk_ill(input logic [31:0] ins, input logic [31:0] pc);
      return mk(ins, pc, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic bump_cnt();
      if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
   endtask

   vec_t vt[22];

   initial begin
      //        instr         pc     ill a  b  alu mreq mwe msz gwe wb br jal jalr mdu mop
      vt[0]  = mk(32'h003100b3, 32'h100, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      vt[1]  = mk(32'h00812283, 32'h104, 0, 0, 1, 0,  1, 0, 2, 1, 1, 0, 0, 0, 0, 0);
      vt[2]  = mk(32'h3e38320f, 32'h108, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[3]  = mk_ill(32'h00000000, 32'h10c);
`ifdef MIRISCV_DECODE_RVM_EN
      vt[4]  = mk(32'h023100b3, 32'h110, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
      vt[21] = mk(32'h023140b3, 32'h154, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 1, 4);
`else
      vt[4]  = mk_ill(32'h023100b3, 32'h110);
      vt[21] = mk_ill(32'h023140b3, 32'h154);
`endif
      vt[5]  = mk(32'h00512223, 32'h114, 0, 0, 3, 0,  1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
      vt[6]  = mk(32'h00208463, 32'h118, 0, 0, 0, 24, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      vt[7]  = mk(32'h000000ef, 32'h11c, 0, 1, 4, 0,  0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      vt[8]  = mk(32'h000100e7, 32'h120, 0, 1, 4, 0,  0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
      vt[9]  = mk(32'h123450b7, 32'h124, 0, 2, 2, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      vt[10] = mk(32'h00000097, 32'h128, 0, 1, 2, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      vt[11] = mk(32'h403100b3, 32'h12c, 0, 0, 0, 8,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      vt[12] = mk(32'h40315093, 32'h130, 0, 0, 1, 13, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      vt[13] = mk(32'h00000073, 32'h134, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[14] = mk_ill(32'h00002063, 32'h138);
      vt[15] = mk_ill(32'h00003003, 32'h13c);
      vt[16] = mk(32'h00513093, 32'h140, 0, 0, 1, 3,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      vt[17] = mk(32'h00511023, 32'h144, 0, 0, 3, 0,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      vt[18] = mk(32'h00100073, 32'h148, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[19] = mk_ill(32'h30001073, 32'h14c);
      vt[20] = mk_ill(32'h803100b3, 32'h150);

      arstn_i = 1'b0; flush_i = 1'b0; instr_valid_i = 1'b0;
      instr_i = '0; pc_i = '0; dec_ready_i = 1'b1;
      tick(); tick();
      chk("rst.dec_valid", dec_valid_o, 0);
      chk("rst.pc", pc_o, 0);
      chk("rst.cnt", illegal_cnt_o, 0);
      chk("rst.gpr_we", gpr_we_a_o, 0);
      arstn_i = 1'b1;
      tick();
      chk("rst.ready", instr_ready_o, 1);

      // Table vectors: accept, no bypass, slot valid two edges after accept, consume.
      for (int i = 0; i < 22; i++) begin
         instr_valid_i = 1'b1; instr_i = vt[i].ins; pc_i = vt[i].pc;
         chk($sformatf("v%0d.ready", i), instr_ready_o, 1);
         tick();
         instr_valid_i = 1'b0;
         chk($sformatf("v%0d.latency", i), dec_valid_o, 0);
         tick();
         chk($sformatf("v%0d.dec_valid", i), dec_valid_o, 1);
         chk($sformatf("v%0d.pc", i), pc_o, vt[i].pc);
         chk($sformatf("v%0d.illegal", i), illegal_instr_o, vt[i].ill);
         chk($sformatf("v%0d.op_a", i), ex_op_a_sel_o, vt[i].a);
         chk($sformatf("v%0d.op_b", i), ex_op_b_sel_o, vt[i].b);
         chk($sformatf("v%0d.alu", i), alu_op_o, vt[i].alu);
         chk($sformatf("v%0d.mem_req", i), mem_req_o, vt[i].mreq);
         chk($sformatf("v%0d.mem_we", i), mem_we_o, vt[i].mwe);
         chk($sformatf("v%0d.mem_size", i), mem_size_o, vt[i].msz);
         chk($sformatf("v%0d.gpr_we", i), gpr_we_a_o, vt[i].gwe);
         chk($sformatf("v%0d.wb_src", i), wb_src_sel_o, vt[i].wb);
         chk($sformatf("v%0d.branch", i), branch_o, vt[i].br);
         chk($sformatf("v%0d.jal", i), jal_o, vt[i].jal);
         chk($sformatf("v%0d.jalr", i), jalr_o, vt[i].jalr);
         chk($sformatf("v%0d.mdu_req", i), mdu_req_o, vt[i].mdu);
         chk($sformatf("v%0d.mdu_op", i), mdu_op_o, vt[i].mop);
         if (vt[i].ill) bump_cnt();
         tick();
         chk($sformatf("v%0d.drain", i), dec_valid_o, 0);
         chk($sformatf("v%0d.cnt", i), illegal_cnt_o, exp_cnt);
      end

      // Stall: lw held for 5 cycles, then fill queue behind it.
      dec_ready_i = 1'b0;
      instr_valid_i = 1'b1; instr_i = 32'h00812283; pc_i = 32'h300;
      tick();
      instr_valid_i = 1'b0;
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("stall.valid", dec_valid_o, 1);
         chk("stall.pc", pc_o, 32'h300);
         chk("stall.mem_req", mem_req_o, 1);
         chk("stall.mem_we", mem_we_o, 0);
         chk("stall.mem_size", mem_size_o, 2);
         chk("stall.wb_src", wb_src_sel_o, 1);
         tick();
      end
      instr_valid_i = 1'b1; instr_i = 32'h003100b3; pc_i = 32'h200;
      tick();
      pc_i = 32'h204;
      tick();
      chk("full.ready_low", instr_ready_o, 0);
      pc_i = 32'h208;
      tick();
      chk("full.ready_still_low", instr_ready_o, 0);
      chk("full.slot_held", pc_o, 32'h300);
      dec_ready_i = 1'b1;
      tick();
      chk("full.pop_pc", pc_o, 32'h200);
      chk("full.ready_rises", instr_ready_o, 1);
      tick();
      instr_valid_i = 1'b0;
      chk("thru.pc", pc_o, 32'h204);
      chk("thru.ready", instr_ready_o, 1);
      tick();
      chk("thru.last_pc", pc_o, 32'h208);
      chk("thru.last_valid", dec_valid_o, 1);
      tick();
      chk("thru.drain_valid", dec_valid_o, 0);
      chk("thru.drain_keeps_pc", pc_o, 32'h208);

      // Flush with illegal word in the slot and a full queue.
      dec_ready_i = 1'b0;
      instr_valid_i = 1'b1; instr_i = 32'h00000000; pc_i = 32'h400;
      tick();
      instr_i = 32'h003100b3; pc_i = 32'h404;
      tick();
      pc_i = 32'h408;
      tick();
      chk("flush.pre_full", instr_ready_o, 0);
      chk("flush.pre_illegal", illegal_instr_o, 1);
      chk("flush.pre_pc", pc_o, 32'h400);
      flush_i = 1'b1; pc_i = 32'h40c;
      chk("flush.ready_during", instr_ready_o, 0);
      tick();
      flush_i = 1'b0; instr_valid_i = 1'b0;
      chk("flush.valid", dec_valid_o, 0);
      chk("flush.empty", instr_ready_o, 1);
      dec_ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("flush.nothing_emerges", dec_valid_o, 0);
      end
      chk("flush.cnt", illegal_cnt_o, exp_cnt);
      flush_i = 1'b1; instr_valid_i = 1'b1; pc_i = 32'h600;
      chk("flush2.ready", instr_ready_o, 1);
      tick();
      flush_i = 1'b0; instr_valid_i = 1'b0;
      tick(); tick();
      chk("flush2.discarded", dec_valid_o, 0);
      instr_valid_i = 1'b1; pc_i = 32'h500;
      tick();
      instr_valid_i = 1'b0;
      tick();
      chk("flush3.valid", dec_valid_o, 1);
      chk("flush3.pc", pc_o, 32'h500);
      tick();
      chk("flush3.drain", dec_valid_o, 0);

      // Saturation: stream 2^CNT_W+3 illegal words.
      instr_valid_i = 1'b1; instr_i = 32'h00000000;
      for (int k = 0; k < (1 << CNT_W) + 3; k++) begin
         pc_i = 32'h1000 + 32'(4 * k);
         bump_cnt();
         tick();
      end
      instr_valid_i = 1'b0;
      tick(); tick(); tick();
      chk("sat.cnt", illegal_cnt_o, exp_cnt);
      chk("sat.all_ones", illegal_cnt_o, 4'hF);

      // Asynchronous reset in the middle of a stream.
      instr_valid_i = 1'b1; instr_i = 32'h00812283; pc_i = 32'h2000;
      tick(); tick();
      chk("arst.pre_valid", dec_valid_o, 1);
      #3 arstn_i = 1'b0;
      #1;
      chk("arst.valid", dec_valid_o, 0);
      chk("arst.pc", pc_o, 0);
      chk("arst.cnt", illegal_cnt_o, 0);
      chk("arst.mem_req", mem_req_o, 0);
      chk("arst.gpr_we", gpr_we_a_o, 0);
      instr_valid_i = 1'b0;
      tick();
      arstn_i = 1'b1;
      tick();
      chk("arst.post_valid", dec_valid_o, 0);
      chk("arst.post_ready", instr_ready_o, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
